// File: rtl/strng_ctrl_pkg.sv
// Shared definitions for the STR TRNG sequencing controller: FSM state
// encoding, state port width and a counter-width helper.
package strng_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strng_ctrl_health.sv
// Repetition-count health test. Tracks the previous raw sample and the length
// of the current run of identical samples; pulses fail for one cycle on the
// strobe whose run length reaches REP_LIMIT.
module strng_health #(
  parameter int STR_LEN   = 8,
  parameter int REP_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               strobe,
  input  logic [STR_LEN-1:0] data,
  output logic               fail
);

  localparam int unsigned CNT_W = $clog2(REP_LIMIT + 1);
  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REP_LIMIT);

  logic [STR_LEN-1:0] last;
  logic [CNT_W-1:0]   rep_cnt;
  logic [CNT_W-1:0]   rep_next;
  logic               first;

  // Run length this strobe would produce; the first sample after clear always starts a new run.
  always_comb begin
    rep_next = CNT_W'(1);
    if (!first && (data == last)) begin
      rep_next = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + 1'b1;
    end
  end

  assign fail = strobe && (rep_next >= REP_MAX);

  // History register: cleared while the controller is outside RUN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last    <= '0;
      rep_cnt <= '0;
      first   <= 1'b1;
    end else if (clear) begin
      last    <= '0;
      rep_cnt <= '0;
      first   <= 1'b1;
    end else if (strobe) begin
      last    <= data;
      rep_cnt <= rep_next;
      first   <= 1'b0;
    end
  end

endmodule

// File: rtl/strng_ctrl.sv
// Sequencing controller for the STR TRNG core: owns the core reset, waits out
// warm-up, decimates the raw random bus, health-tests every sample and packs
// samples into OUT_W-bit words behind a one-word valid/ready output buffer.
module strng_ctrl
  import strng_ctrl_pkg::*;
#(
  parameter int STR_LEN    = 8,
  parameter int OUT_W      = 32,
  parameter int SAMPLE_DIV = 4,
  parameter int WARMUP_CYC = 256,
  parameter int REP_LIMIT  = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  output logic               core_rstn,
  input  logic [STR_LEN-1:0] rnd_data,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               health_fail,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned SLICES = OUT_W / STR_LEN;
  localparam int unsigned WCNT_W = cnt_width(WARMUP_CYC);
  localparam int unsigned DIV_W  = cnt_width(SAMPLE_DIV);
  localparam int unsigned PCNT_W = cnt_width(SLICES);

  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP_CYC - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [PCNT_W-1:0] PACK_LAST = PCNT_W'(SLICES - 1);

  state_t              state_q;
  logic [WCNT_W-1:0]   warm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [PCNT_W-1:0]   pack_cnt;
  logic [OUT_W-1:0]    pack_reg;
  logic [OUT_W-1:0]    pack_next;
  logic                pack_full;
  logic                strobe;
  logic                xfer;
  logic                rep_fail;
  logic                health_clear;

  assign state        = state_q;
  assign strobe       = (state_q == ST_RUN) && enable && (div_cnt == DIV_LAST);
  assign xfer         = out_valid && out_ready;
  assign health_clear = (state_q != ST_RUN);

  // Pack register with the current sample dropped into the next free slice.
  always_comb begin
    pack_next = pack_reg;
    pack_next[int'(pack_cnt) * STR_LEN +: STR_LEN] = rnd_data;
  end

  strng_health #(
    .STR_LEN   (STR_LEN),
    .REP_LIMIT (REP_LIMIT)
  ) u_health (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (health_clear),
    .strobe (strobe),
    .data   (rnd_data),
    .fail   (rep_fail)
  );

  // Sequencing FSM with warm-up counter, sample divider, packer and output buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      core_rstn   <= 1'b0;
      warm_cnt    <= '0;
      div_cnt     <= '0;
      pack_cnt    <= '0;
      pack_reg    <= '0;
      pack_full   <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      health_fail <= 1'b0;
    end else if (((state_q == ST_WARMUP) || (state_q == ST_RUN)) && !enable) begin
      state_q   <= ST_IDLE;
      core_rstn <= 1'b0;
      out_valid <= 1'b0;
      pack_cnt  <= '0;
      pack_reg  <= '0;
      pack_full <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q   <= ST_WARMUP;
            warm_cnt  <= '0;
            core_rstn <= 1'b1;
          end
        end
        ST_WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            state_q   <= ST_RUN;
            div_cnt   <= '0;
            pack_cnt  <= '0;
            pack_full <= 1'b0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (rep_fail) begin
            // A failing strobe wins over any word it would have completed.
            state_q     <= ST_FAIL;
            health_fail <= 1'b1;
            core_rstn   <= 1'b0;
            out_valid   <= 1'b0;
            pack_cnt    <= '0;
            pack_reg    <= '0;
            pack_full   <= 1'b0;
          end else begin
            div_cnt <= strobe ? '0 : div_cnt + 1'b1;
            if (xfer) begin
              out_valid <= 1'b0;
              if (pack_full) begin
                out_data  <= pack_reg;
                out_valid <= 1'b1;
                pack_full <= 1'b0;
              end
            end
            // Samples arriving while a complete word waits are tested but not kept.
            if (strobe && !pack_full) begin
              pack_reg <= pack_next;
              if (pack_cnt == PACK_LAST) begin
                pack_cnt <= '0;
                if (!out_valid || out_ready) begin
                  out_data  <= pack_next;
                  out_valid <= 1'b1;
                end else begin
                  pack_full <= 1'b1;
                end
              end else begin
                pack_cnt <= pack_cnt + 1'b1;
              end
            end
          end
        end
        ST_FAIL: begin
          if (!enable) begin
            state_q     <= ST_IDLE;
            health_fail <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
